// File: rtl/max7219_chain_monitor.sv
// Passive monitor for a cascaded MAX7219 SPI chain: frames, length errors, frame count.
// Optional per-device digit-row shadow memory under `define MAX7219_CHAIN_MONITOR_SHADOW_EN.
module max7219_chain_monitor #(
  parameter int G_NB_MATRIX   = 8,
  parameter int G_SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_max7219_clk,
  input  logic                      i_max7219_din,
  input  logic                      i_max7219_load,
  output logic                      o_frame_received,
  output logic                      o_load_received,
  output logic [G_NB_MATRIX*16-1:0] o_data_received,
  output logic                      o_error,
  output logic [1:0]                o_error_code,
  output logic [15:0]               o_frame_cnt,
  input  logic [3:0]                i_rd_matrix,
  input  logic [2:0]                i_rd_row,
  output logic [7:0]                o_rd_data
);

  localparam int W  = G_NB_MATRIX * 16;
  localparam int CW = $clog2(W + 2);
  localparam logic [CW-1:0] FULL = CW'(W);
  localparam logic [CW-1:0] SAT  = CW'(W + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_OVF   = 2'd2;

  logic [G_SYNC_STAGES-1:0] sync_clk, sync_din, sync_load;
  logic          clk_prev, load_prev;
  logic          spi_rise, load_rise, din_q;
  logic [W-1:0]  sr, sr_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0]    state, state_nx;
  logic          frame_hit, valid, short_f, long_f;

  // Edge pulses are registered together with the matching din sample so they stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_clk  <= '0;
      sync_din  <= '0;
      sync_load <= '0;
      clk_prev  <= 1'b0;
      load_prev <= 1'b0;
      spi_rise  <= 1'b0;
      load_rise <= 1'b0;
      din_q     <= 1'b0;
    end else begin
      sync_clk  <= {sync_clk[G_SYNC_STAGES-2:0], i_max7219_clk};
      sync_din  <= {sync_din[G_SYNC_STAGES-2:0], i_max7219_din};
      sync_load <= {sync_load[G_SYNC_STAGES-2:0], i_max7219_load};
      clk_prev  <= sync_clk[G_SYNC_STAGES-1];
      load_prev <= sync_load[G_SYNC_STAGES-1];
      spi_rise  <= sync_clk[G_SYNC_STAGES-1] & ~clk_prev;
      load_rise <= sync_load[G_SYNC_STAGES-1] & ~load_prev;
      din_q     <= sync_din[G_SYNC_STAGES-1];
    end
  end

  // A shift coinciding with a load edge is applied first; the load sees the post-shift length.
  always_comb begin
    sr_nx    = sr;
    cnt_nx   = cnt;
    state_nx = state;
    if (spi_rise) begin
      sr_nx = {sr[W-2:0], din_q};
      if (cnt != SAT) cnt_nx = cnt + 1'b1;
    end
    case (state)
      ST_IDLE:  if (spi_rise) state_nx = ST_SHIFT;
      ST_SHIFT: if (cnt_nx > FULL) state_nx = ST_OVF;
      ST_OVF:   state_nx = ST_OVF;
      default:  state_nx = ST_IDLE;
    endcase
    frame_hit = spi_rise && (cnt_nx[3:0] == 4'd0) && (cnt_nx != '0) && (cnt_nx <= FULL);
    valid     = load_rise && (state_nx == ST_SHIFT) && (cnt_nx == FULL);
    short_f   = load_rise && (state_nx == ST_SHIFT) && (cnt_nx != FULL);
    long_f    = load_rise && (state_nx == ST_OVF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr               <= '0;
      cnt              <= '0;
      state            <= ST_IDLE;
      o_frame_received <= 1'b0;
      o_load_received  <= 1'b0;
      o_data_received  <= '0;
      o_error          <= 1'b0;
      o_error_code     <= 2'b00;
      o_frame_cnt      <= '0;
    end else begin
      sr               <= sr_nx;
      cnt              <= load_rise ? '0 : cnt_nx;
      state            <= load_rise ? ST_IDLE : state_nx;
      o_frame_received <= frame_hit;
      o_load_received  <= valid;
      o_error          <= short_f | long_f;
      if (valid) begin
        o_data_received <= sr_nx;
        if (o_frame_cnt != 16'hFFFF) o_frame_cnt <= o_frame_cnt + 16'd1;
      end
      if (short_f) o_error_code <= 2'b01;
      if (long_f)  o_error_code <= 2'b10;
    end
  end

`ifdef MAX7219_CHAIN_MONITOR_SHADOW_EN
  // Sized for the full 4-bit index; rows of absent devices stay constant zero.
  logic [7:0] shadow [16][8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned d = 0; d < 16; d++)
        for (int unsigned r = 0; r < 8; r++)
          shadow[d][r] <= '0;
    end else if (valid) begin
      for (int unsigned d = 0; d < G_NB_MATRIX; d++)
        if (sr_nx[d*16+8 +: 4] >= 4'd1 && sr_nx[d*16+8 +: 4] <= 4'd8)
          shadow[d][3'(sr_nx[d*16+8 +: 4] - 4'd1)] <= sr_nx[d*16 +: 8];
    end
  end

  assign o_rd_data = ({1'b0, i_rd_matrix} < 5'(G_NB_MATRIX)) ? shadow[i_rd_matrix][i_rd_row] : '0;
`else
  logic unused_rd;
  assign unused_rd = ^{i_rd_matrix, i_rd_row};
  assign o_rd_data = '0;
`endif

endmodule

// File: tb/tb_max7219_chain_monitor.sv
// Directed bench for max7219_chain_monitor (8 devices, 2 sync stages); shadow checks
// follow `define MAX7219_CHAIN_MONITOR_SHADOW_EN.
module tb_max7219_chain_monitor;
  localparam int N = 8;
  localparam int S = 2;
  localparam int W = N * 16;
`ifdef MAX7219_CHAIN_MONITOR_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic spi_clk = 1'b0, spi_din = 1'b0, spi_load = 1'b0;
  logic [3:0] rd_matrix = '0;
  logic [2:0] rd_row = '0;
  logic frame_received, load_received, error;
  logic [W-1:0] data_received;
  logic [1:0] error_code;
  logic [15:0] frame_cnt;
  logic [7:0] rd_data;

  int vectors = 0, miscompares = 0;
  int n_frame = 0, n_load = 0, n_err = 0;
  int b_frame, b_load, b_err;
  logic [15:0] frame_w [8];
  logic [W-1:0] exp_data;

  max7219_chain_monitor #(.G_NB_MATRIX(N), .G_SYNC_STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_max7219_clk(spi_clk), .i_max7219_din(spi_din), .i_max7219_load(spi_load),
    .o_frame_received(frame_received), .o_load_received(load_received),
    .o_data_received(data_received), .o_error(error), .o_error_code(error_code),
    .o_frame_cnt(frame_cnt), .i_rd_matrix(rd_matrix), .i_rd_row(rd_row),
    .o_rd_data(rd_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_received) n_frame++;
    if (load_received) n_load++;
    if (error) n_err++;
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bit(input logic b);
    @(negedge clk);
    spi_din = b;
    spi_clk = 1'b0;
    repeat (4) @(negedge clk);
    spi_clk = 1'b1;
    repeat (4) @(negedge clk);
    spi_clk = 1'b0;
  endtask

  task automatic send_bits(input logic [15:0] w, input int n);
    for (int k = 0; k < n; k++) spi_bit(w[15 - (k % 16)]);
  endtask

  task automatic send_frame();
    exp_data = '0;
    for (int j = 0; j < 8; j++) begin
      send_bits(frame_w[j], 16);
      exp_data = {exp_data[W-17:0], frame_w[j]};
    end
  endtask

  task automatic do_load();
    @(negedge clk);
    spi_load = 1'b1;
    repeat (8) @(negedge clk);
    spi_load = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic snap();
    b_frame = n_frame;
    b_load  = n_load;
    b_err   = n_err;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_data", data_received, '0);
    check("rst_cnt", frame_cnt, 0);
    check("rst_code", error_code, 0);
    check("rst_pulses", {frame_received, load_received, error}, 0);
    check("rst_rd", rd_data, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Load with no SPI clocks is ignored
    snap();
    do_load();
    check("idle_load", n_load - b_load, 0);
    check("idle_err", n_err - b_err, 0);
    check("idle_cnt", frame_cnt, 0);

    // 128 bits of 0155 with exact load latency
    snap();
    send_bits(16'h0155, 128);
    repeat (6) @(negedge clk);
    check("f1_frames", n_frame - b_frame, 8);
    spi_load = 1'b1;
    repeat (S + 1) @(posedge clk);
    #1 check("lat_early", load_received, 0);
    @(posedge clk);
    #1 check("lat_hit", load_received, 1);
    @(posedge clk);
    #1 check("lat_end", load_received, 0);
    @(negedge clk);
    spi_load = 1'b0;
    repeat (8) @(negedge clk);
    check("f1_loads", n_load - b_load, 1);
    check("f1_err", n_err - b_err, 0);
    check("f1_data", data_received, {8{16'h0155}});
    check("f1_cnt", frame_cnt, 1);

    // Short frame: 127 bits
    snap();
    send_bits(16'h1234, 127);
    do_load();
    check("short_frames", n_frame - b_frame, 7);
    check("short_err", n_err - b_err, 1);
    check("short_code", error_code, 2'b01);
    check("short_loads", n_load - b_load, 0);
    check("short_cnt", frame_cnt, 1);
    check("short_data", data_received, {8{16'h0155}});

    // Long frame: 130 bits, then a normal frame
    snap();
    send_bits(16'hBEEF, 130);
    do_load();
    check("long_frames", n_frame - b_frame, 8);
    check("long_err", n_err - b_err, 1);
    check("long_code", error_code, 2'b10);
    check("long_loads", n_load - b_load, 0);
    check("long_data", data_received, {8{16'h0155}});
    snap();
    for (int j = 0; j < 8; j++) frame_w[j] = 16'hA000 + 16'(j * 16'h0111);
    send_frame();
    do_load();
    check("after_long_loads", n_load - b_load, 1);
    check("after_long_err", n_err - b_err, 0);
    check("after_long_data", data_received, exp_data);
    check("after_long_cnt", frame_cnt, 2);
    check("code_held", error_code, 2'b10);

    // Shadow rows: device d is frame word 7-d
    for (int j = 0; j < 8; j++) frame_w[j] = 16'h0000;
    frame_w[4] = 16'h0AA5;
    frame_w[7] = 16'h0811;
    send_frame();
    do_load();
    check("sh1_cnt", frame_cnt, 3);
    rd_matrix = 4'd3; rd_row = 3'd1;
    #1 check("sh_addr_a_ignored", rd_data, 0);
    rd_matrix = 4'd0; rd_row = 3'd7;
    #1 check("sh_dev0_row7", rd_data, SHADOW ? 8'h11 : 8'h00);
    frame_w[4] = 16'h03C3;
    frame_w[7] = 16'h0000;
    send_frame();
    do_load();
    check("sh2_cnt", frame_cnt, 4);
    check("sh2_data", data_received, exp_data);
    rd_matrix = 4'd3; rd_row = 3'd2;
    #1 check("sh_dev3_row2", rd_data, SHADOW ? 8'hC3 : 8'h00);
    rd_matrix = 4'd3; rd_row = 3'd1;
    #1 check("sh_dev3_row1", rd_data, 0);
    rd_matrix = 4'd0; rd_row = 3'd7;
    #1 check("sh_dev0_kept", rd_data, SHADOW ? 8'h11 : 8'h00);
    rd_matrix = 4'd9; rd_row = 3'd2;
    #1 check("sh_out_of_range", rd_data, 0);

    // Reset mid-frame discards partial traffic
    send_bits(16'hFFFF, 64);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_cnt", frame_cnt, 0);
    check("mid_rst_data", data_received, '0);
    check("mid_rst_code", error_code, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    snap();
    for (int j = 0; j < 8; j++) frame_w[j] = 16'h5A00 + 16'(j * 16'h0013);
    send_frame();
    do_load();
    check("post_rst_loads", n_load - b_load, 1);
    check("post_rst_err", n_err - b_err, 0);
    check("post_rst_data", data_received, exp_data);
    check("post_rst_cnt", frame_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/max7219_chain_monitor.md
MAX7219_CHAIN_MONITOR -- requirements
Module: max7219_chain_monitor

Interface
REQ-001 Parameter G_NB_MATRIX, default 8: number of cascaded MAX7219 devices monitored, legal range 1..16.
REQ-002 Parameter G_SYNC_STAGES, default 2: synchroniser depth on every i_max7219_* input, legal range 2..4.
REQ-003 clk  in  1  single clock for the whole block.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 i_max7219_clk  in  1  SPI clock from DUT, asynchronous to clk.
REQ-006 i_max7219_din  in  1  SPI data from DUT.
REQ-007 i_max7219_load  in  1  SPI load/CS from DUT.
REQ-008 o_frame_received  out  1  one-clk pulse per complete 16-bit word shifted.
REQ-009 o_load_received  out  1  one-clk pulse per load rising edge that closes a correct-length chain frame.
REQ-010 o_data_received  out  G_NB_MATRIX*16  captured chain frame; bits [15:0] belong to the device nearest the DUT (last shifted word).
REQ-011 o_error  out  1  one-clk pulse per load rising edge closing a wrong-length frame.
REQ-012 o_error_code  out  2  01 short frame, 10 long frame, held until next o_error.
REQ-013 o_frame_cnt  out  16  count of valid chain frames, saturating at 16'hFFFF.
REQ-014 i_rd_matrix  in  4  shadow read: device index (ignored when index >= G_NB_MATRIX).
REQ-015 i_rd_row  in  3  shadow read: digit row 0..7 (MAX7219 addresses 1..8).
REQ-016 o_rd_data  out  8  shadow read data, combinational from i_rd_matrix/i_rd_row.

Function
REQ-017 All three SPI inputs SHALL pass through identical G_SYNC_STAGES flip-flop synchronisers so din and clk stay aligned.
REQ-018 Rising edge of synchronised SPI clock SHALL shift synchronised din into the G_NB_MATRIX*16 shift register MSB-first and increment the bit counter.
REQ-019 Bit counter SHALL saturate at G_NB_MATRIX*16+1; no wrap-around.
REQ-020 o_frame_received SHALL pulse the cycle after each shift that makes the counter a non-zero multiple of 16, up to G_NB_MATRIX*16.
REQ-021 FSM states: IDLE (counter 0), SHIFT (1..N*16 bits), OVF (counter > N*16); IDLE->SHIFT on first clock edge, SHIFT->OVF on bit N*16+1, any state->IDLE on load rising edge.
REQ-022 Load rising edge in SHIFT with counter == N*16: latch shift register into o_data_received, pulse o_load_received, increment o_frame_cnt, all registered one clk after edge detection.
REQ-023 Load rising edge in SHIFT with counter < N*16: pulse o_error, code 01; o_data_received unchanged.
REQ-024 Load rising edge in OVF: pulse o_error, code 10; o_data_received unchanged.
REQ-025 Load rising edge in IDLE SHALL be ignored (no pulse, no count).
REQ-026 SPI clock edge and load edge detected in same clk cycle: shift SHALL be applied first and length evaluated including that bit.
REQ-027 Shift register contents SHALL not be cleared by load; counter clears to 0.
REQ-028 Input-to-output latency: o_load_received asserts G_SYNC_STAGES+1 clk cycles after the first clk edge sampling load high.

Reset
REQ-029 On rst_n low, immediately: all outputs 0, o_error_code 00, counter 0, FSM IDLE, shift register 0, shadow registers 0, synchronisers 0.
REQ-030 Reset mid-frame SHALL discard the partial frame; the first load after release SHALL be evaluated from bit 0 of new traffic.

Configuration
REQ-031 Macro MAX7219_CHAIN_MONITOR_SHADOW_EN: defined -> on every valid chain frame, each device word whose address nibble [11:8] is 1..8 SHALL write data [7:0] into shadow row (address-1) of that device; other addresses ignored.
REQ-032 Without MAX7219_CHAIN_MONITOR_SHADOW_EN: no shadow storage synthesised, o_rd_data tied to 8'h00, i_rd_* unused.

Verification
REQ-033 G_NB_MATRIX=8, 128 bits of 16'h0155 repeated, load -> o_frame_received 8 pulses, o_load_received 1 pulse, o_data_received = {8{16'h0155}}, o_frame_cnt=1.
REQ-034 Send 127 bits then load -> o_error pulse, o_error_code=01, o_load_received stays 0, o_frame_cnt unchanged.
REQ-035 Send 130 bits then load -> OVF reached, o_error pulse, o_error_code=10; next 128-bit frame accepted normally.
REQ-036 SHADOW_EN defined, frame with device 3 word 16'h0AA5 -> i_rd_matrix=3,i_rd_row=1 gives 8'h00... (address 0xA ignored); word 16'h03C3 -> row 2 reads 8'hC3.
REQ-037 rst_n pulsed after 64 bits, then full 128-bit frame and load -> single o_load_received, no o_error, data equals new frame only.
REQ-038 Load asserted with no preceding SPI clock -> no o_load_received, no o_error, counters unchanged.
